// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
//
// Bit-serial subtractor: computes diff = a - b - bin (mod 2^W) one bit per
// clock, LSB first, with a single full-subtractor cell and a registered
// borrow. Handshake: start/ready to launch, out_valid/out_ready to retire.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      launch request, honoured only while ready=1
//   a, b, bin  minuend, subtrahend, borrow-in (sampled on accepted start)
//   clear      synchronous abort back to IDLE, wins over start/out_ready
//   ready      1 in IDLE
//   busy       1 in RUN
//   out_valid  1 in DONE; diff/bout (and ovf) valid
//   out_ready  consumer accepts the result
//   diff       W-bit difference
//   bout       final borrow-out (a < b + bin, unsigned)
//   ovf        signed overflow, present only when SERIAL_SUB_OVF_EN is defined
//
// Optional feature macro: SERIAL_SUB_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  input  logic         clear,
  output logic         ready,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_sh, b_sh, diff_reg, diff_shift;
  logic           br, br_next, d, bout_reg;
  logic [CW-1:0]  cnt;
  logic           x, y, last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic           ovf_reg;
`endif

  // Full-subtractor cell on the current LSBs.
  assign x        = a_sh[0];
  assign y        = b_sh[0];
  assign d        = x ^ y ^ br;
  assign br_next  = (~x & y) | (br & ~(x ^ y));
  assign last_bit = (cnt == LAST);

  // New difference bit enters at the MSB so that after W shifts bit 0 sits
  // at position 0. Written this way so it also holds for W=1.
  always_comb begin
    diff_shift        = diff_reg >> 1;
    diff_shift[W-1]   = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_reg <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bout_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_reg  <= 1'b0;
`endif
    end else if (clear) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_reg <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bout_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            br       <= bin;
            diff_reg <= '0;
            cnt      <= '0;
            bout_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg  <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          diff_reg <= diff_shift;
          br       <= br_next;
          cnt      <= cnt + CW'(1);
          if (last_bit) begin
            bout_reg <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            // x/y are the original operand MSBs on the final bit; d is the
            // result MSB.
            ovf_reg  <= (x != y) & (d != x);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule
